filtro_iir_seq: RTL and testbench
=================================

FILTRO_IIR_SEQ -- requirements
Module: filtro_iir_seq

Interface
REQ-001 Parameter cant_bits, default 25, SHALL set the width of samples, coefficients and output (two's complement).
REQ-002 Parameter frac_bits, default 14, SHALL set the fractional bits of coefficients (1.0 = 2^frac_bits).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to filter x_in.
REQ-006 x_in  input  cant_bits  signed input sample, same scale as y_out.
REQ-007 sel_cte  output  4  coefficient select driven to the coefficient ROM.
REQ-008 cte  input  cant_bits  signed coefficient returned combinationally by the ROM for the current sel_cte.
REQ-009 y_out  output  cant_bits  signed filtered sample, held until the next update.
REQ-010 done  output  1  one-cycle pulse: y_out newly valid.
REQ-011 busy  output  1  high from start acceptance until done.
REQ-012 sat  output  1  valid with done; high when y_out was clamped.

Function
REQ-013 The block SHALL compute Direct Form I biquad: y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + (-a1)*y[n-1] + (-a2)*y[n-2].
REQ-014 Coefficient codes SHALL be: 4'b0101 b0, 4'b0110 b1, 4'b0111 b2, 4'b0001 -a1, 4'b0010 -a2; 4'b0000 (unity) SHALL be driven whenever not in MAC.
REQ-015 FSM states SHALL be IDLE, MAC, OUT; reset state IDLE.
REQ-016 IDLE: on edge with start=1, SHALL capture x_in into x0, clear accumulator, idx<=0, go MAC; otherwise stay.
REQ-017 MAC: sel_cte SHALL follow idx order 0..4 = b0,b1,b2,-a1,-a2 paired with x0,x1,x2,y1,y2; each edge SHALL add cte*operand to accumulator; after idx=4 go OUT.
REQ-018 OUT: one edge SHALL load y_out, pulse done and sat, shift x2<=x1, x1<=x0, y2<=y1, y1<=y_out(new), go IDLE.
REQ-019 Latency: done SHALL be high in the 6th cycle after the cycle in which start was sampled; maximum rate one sample per 7 cycles.
REQ-020 Accumulator SHALL be signed 2*cant_bits+3 bits; no overflow possible in 5 products.
REQ-021 Result SHALL be rounded half-up (add 2^(frac_bits-1), arithmetic shift right frac_bits), then saturated to [-(2^(cant_bits-1)), 2^(cant_bits-1)-1].
REQ-022 History SHALL store the saturated y_out.
REQ-023 start while busy SHALL be ignored (no capture, no queueing); start in the cycle done is high SHALL be accepted.
REQ-024 busy SHALL be combinationally (state != IDLE).

Reset
REQ-025 reset low SHALL immediately force: state IDLE, idx 0, accumulator 0, x0/x1/x2/y1/y2 0, y_out 0, done 0, sat 0, busy 0, sel_cte 4'b0000.
REQ-026 Reset mid-MAC or mid-OUT SHALL abandon the sample; no done pulse SHALL follow release.

Structure
REQ-027 Shared package SHALL hold cant_bits/frac_bits defaults, FSM state encodings and the five sel_cte codes.
REQ-028 Round-and-saturate SHALL be one sub-module, redondeo_sat; the coefficient ROM SHALL stay external.

Verification
REQ-029 Reset: assert reset low mid-MAC -> all outputs 0, sel_cte 0000 at once; no done after release.
REQ-030 Impulse with high-pass coefficient set: x = 0x0004000 then 0 -> y0 = 0x0003FDF, y1 = 0x1FFFFBE (-66), each with sat=0.
REQ-031 Sequencing: one start -> sel_cte 0101,0110,0111,0001,0010 on consecutive cycles, done 6 cycles after start.
REQ-032 Saturation: x = 0x0FFFFFF then 0x1000000 -> second y_out = 0x1000000, sat=1.
REQ-033 Back-to-back: start held high 21 cycles -> exactly 3 done pulses, 7 cycles apart; starts during busy produce no capture.

Source files
------------

// File: rtl/filtro_iir_seq_pkg.sv
// ---------------------------------------------------------------------------
// filtro_iir_seq_pkg
// Shared definitions for the sequential biquad IIR filter:
//   - default sample/coefficient width and fractional bits
//   - FSM state encoding
//   - coefficient-select codes presented to the external coefficient ROM
//   - helper mapping the MAC step index to its coefficient code
// ---------------------------------------------------------------------------
package filtro_iir_seq_pkg;

    localparam int cant_bits_def = 25;
    localparam int frac_bits_def = 14;

    // Number of multiply-accumulate steps of one biquad evaluation.
    localparam int num_taps = 5;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_mac  = 2'd1,
        st_out  = 2'd2
    } estado_t;

    // Coefficient ROM select codes.
    localparam logic [3:0] sel_unit = 4'b0000;  // unity, idle value
    localparam logic [3:0] sel_b0   = 4'b0101;
    localparam logic [3:0] sel_b1   = 4'b0110;
    localparam logic [3:0] sel_b2   = 4'b0111;
    localparam logic [3:0] sel_na1  = 4'b0001;  // -a1
    localparam logic [3:0] sel_na2  = 4'b0010;  // -a2

    // MAC step order: b0, b1, b2, -a1, -a2.
    function automatic logic [3:0] sel_de_idx(input logic [2:0] idx);
        logic [3:0] code;
        case (idx)
            3'd0:    code = sel_b0;
            3'd1:    code = sel_b1;
            3'd2:    code = sel_b2;
            3'd3:    code = sel_na1;
            3'd4:    code = sel_na2;
            default: code = sel_unit;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/filtro_iir_seq_if.sv
// ---------------------------------------------------------------------------
// filtro_iir_seq_if
// Sample/handshake bundle of the sequential biquad filter.
//   start   : one-cycle request to filter x_in
//   x_in    : signed input sample
//   sel_cte : coefficient select towards the external ROM
//   cte     : signed coefficient returned combinationally by the ROM
//   y_out   : signed filtered sample, held until next update
//   done    : one-cycle pulse, y_out newly valid
//   busy    : high while a sample is being processed
//   sat     : valid with done, high when y_out was clamped
// Modports: slave = filter side, master = requester/ROM side.
// ---------------------------------------------------------------------------
interface filtro_iir_seq_if
    import filtro_iir_seq_pkg::*;
#(
    parameter int cant_bits = cant_bits_def
);
    logic                        start;
    logic signed [cant_bits-1:0] x_in;
    logic        [3:0]           sel_cte;
    logic signed [cant_bits-1:0] cte;
    logic signed [cant_bits-1:0] y_out;
    logic                        done;
    logic                        busy;
    logic                        sat;

    modport slave (
        input  start, x_in, cte,
        output sel_cte, y_out, done, busy, sat
    );

    modport master (
        output start, x_in, cte,
        input  sel_cte, y_out, done, busy, sat
    );

endinterface

// File: rtl/filtro_iir_seq_redondeo_sat.sv
// ---------------------------------------------------------------------------
// redondeo_sat
// Converts the wide accumulator to an output sample: round half-up
// (add 2^(frac_bits-1), arithmetic shift right by frac_bits), then clamp
// to the signed cant_bits range.
//   acc : signed accumulator, acc_bits wide
//   y   : rounded, saturated sample
//   sat : high when the clamp was applied
// ---------------------------------------------------------------------------
module redondeo_sat
    import filtro_iir_seq_pkg::*;
#(
    parameter int cant_bits = cant_bits_def,
    parameter int frac_bits = frac_bits_def,
    parameter int acc_bits  = 2 * cant_bits + 3
) (
    input  logic signed [acc_bits-1:0]  acc,
    output logic signed [cant_bits-1:0] y,
    output logic                        sat
);

    // One guard bit so the rounding addend can never wrap.
    localparam logic signed [acc_bits:0] medio =
        {{(acc_bits + 1 - frac_bits){1'b0}}, 1'b1, {(frac_bits - 1){1'b0}}};
    localparam logic signed [acc_bits:0] y_max =
        {{(acc_bits - cant_bits + 2){1'b0}}, {(cant_bits - 1){1'b1}}};
    localparam logic signed [acc_bits:0] y_min =
        {{(acc_bits - cant_bits + 2){1'b1}}, {(cant_bits - 1){1'b0}}};

    logic signed [acc_bits:0] suma;
    logic signed [acc_bits:0] redondeado;

    assign suma       = {acc[acc_bits-1], acc} + medio;
    assign redondeado = suma >>> frac_bits;

    always_comb begin
        y   = redondeado[cant_bits-1:0];
        sat = 1'b0;
        if (redondeado > y_max) begin
            y   = y_max[cant_bits-1:0];
            sat = 1'b1;
        end else if (redondeado < y_min) begin
            y   = y_min[cant_bits-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/filtro_iir_seq.sv
// ---------------------------------------------------------------------------
// filtro_iir_seq
// Sequential Direct Form I biquad using a single multiplier:
//   y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + (-a1)*y[n-1] + (-a2)*y[n-2]
// One sample takes: IDLE (capture) -> 5 MAC steps -> OUT (round, saturate,
// shift history). done rises 6 edges after the edge that accepted start.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : filtro_iir_seq_if.slave (start/x_in/cte in, sel_cte/y_out/
//           done/busy/sat out)
// ---------------------------------------------------------------------------
module filtro_iir_seq
    import filtro_iir_seq_pkg::*;
#(
    parameter int cant_bits = cant_bits_def,
    parameter int frac_bits = frac_bits_def
) (
    input  logic             clk,
    input  logic             reset,
    filtro_iir_seq_if.slave  bus
);

    localparam int acc_bits  = 2 * cant_bits + 3;
    localparam int prod_bits = 2 * cant_bits;

    estado_t                      estado_reg;
    logic        [2:0]            idx_reg;
    logic signed [acc_bits-1:0]   acc_reg;
    logic signed [cant_bits-1:0]  x_hist_reg [3];   // x0, x1, x2
    logic signed [cant_bits-1:0]  y_hist_reg [2];   // y1, y2
    logic signed [cant_bits-1:0]  y_out_reg;
    logic                         done_reg;
    logic                         sat_reg;
    logic        [3:0]            sel_reg;

    logic signed [cant_bits-1:0]  operandos [num_taps];
    logic signed [cant_bits-1:0]  operando;
    logic signed [prod_bits-1:0]  producto;
    logic signed [acc_bits-1:0]   acc_next;
    logic signed [cant_bits-1:0]  y_sat;
    logic                         sat_calc;

    // Operand order matches the coefficient order b0,b1,b2,-a1,-a2.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_op_x
            assign operandos[gi] = x_hist_reg[gi];
        end
        for (gi = 0; gi < 2; gi++) begin : g_op_y
            assign operandos[gi + 3] = y_hist_reg[gi];
        end
    endgenerate

    always_comb begin
        operando = '0;
        if (idx_reg <= 3'd4) begin
            operando = operandos[idx_reg];
        end
    end

    // cte is the ROM answer for the registered sel_cte of this step.
    assign producto = prod_bits'(bus.cte) * prod_bits'(operando);
    assign acc_next = acc_reg + acc_bits'(producto);

    redondeo_sat #(
        .cant_bits (cant_bits),
        .frac_bits (frac_bits),
        .acc_bits  (acc_bits)
    ) u_redondeo_sat (
        .acc (acc_reg),
        .y   (y_sat),
        .sat (sat_calc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_reg <= st_idle;
            idx_reg    <= 3'd0;
            acc_reg    <= '0;
            for (int i = 0; i < 3; i++) x_hist_reg[i] <= '0;
            for (int i = 0; i < 2; i++) y_hist_reg[i] <= '0;
            y_out_reg  <= '0;
            done_reg   <= 1'b0;
            sat_reg    <= 1'b0;
            sel_reg    <= sel_unit;
        end else begin
            done_reg <= 1'b0;
            sat_reg  <= 1'b0;
            case (estado_reg)
                st_idle: begin
                    if (bus.start) begin
                        x_hist_reg[0] <= bus.x_in;
                        acc_reg       <= '0;
                        idx_reg       <= 3'd0;
                        sel_reg       <= sel_b0;
                        estado_reg    <= st_mac;
                    end
                end
                st_mac: begin
                    acc_reg <= acc_next;
                    if (idx_reg == 3'd4) begin
                        sel_reg    <= sel_unit;
                        estado_reg <= st_out;
                    end else begin
                        idx_reg <= idx_reg + 3'd1;
                        sel_reg <= sel_de_idx(idx_reg + 3'd1);
                    end
                end
                st_out: begin
                    y_out_reg     <= y_sat;
                    done_reg      <= 1'b1;
                    sat_reg       <= sat_calc;
                    x_hist_reg[2] <= x_hist_reg[1];
                    x_hist_reg[1] <= x_hist_reg[0];
                    // History keeps the saturated output, not the raw sum.
                    y_hist_reg[1] <= y_hist_reg[0];
                    y_hist_reg[0] <= y_sat;
                    idx_reg       <= 3'd0;
                    estado_reg    <= st_idle;
                end
                default: begin
                    estado_reg <= st_idle;
                end
            endcase
        end
    end

    assign bus.sel_cte = sel_reg;
    assign bus.y_out   = y_out_reg;
    assign bus.done    = done_reg;
    assign bus.sat     = sat_reg;
    assign bus.busy    = (estado_reg != st_idle);

endmodule

// File: tb/tb_filtro_iir_seq.sv
// ---------------------------------------------------------------------------
// tb_filtro_iir_seq
// Directed bench for filtro_iir_seq with a high-pass coefficient ROM model.
// ---------------------------------------------------------------------------
module tb_filtro_iir_seq;
    import filtro_iir_seq_pkg::*;

    localparam int cb = 25;
    localparam int fb = 14;

    // High-pass coefficient set, Q(fb).
    localparam logic signed [cb-1:0] c_b0  =  25'sd16351;
    localparam logic signed [cb-1:0] c_b1  = -25'sd32702;
    localparam logic signed [cb-1:0] c_b2  =  25'sd16351;
    localparam logic signed [cb-1:0] c_na1 =  25'sd32702;
    localparam logic signed [cb-1:0] c_na2 = -25'sd16021;
    localparam logic signed [cb-1:0] c_one =  25'sd16384;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    filtro_iir_seq_if #(.cant_bits(cb)) bus_if ();

    filtro_iir_seq #(
        .cant_bits (cb),
        .frac_bits (fb)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // External coefficient ROM.
    always_comb begin
        case (bus_if.sel_cte)
            sel_b0:   bus_if.cte = c_b0;
            sel_b1:   bus_if.cte = c_b1;
            sel_b2:   bus_if.cte = c_b2;
            sel_na1:  bus_if.cte = c_na1;
            sel_na2:  bus_if.cte = c_na2;
            sel_unit: bus_if.cte = c_one;
            default:  bus_if.cte = '0;
        endcase
    end

    int errors = 0;
    int checks = 0;

    logic [cb-1:0] y_got;
    logic          sat_got;

    task automatic chk_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One full sample: checks latency, sel_cte sequence and busy at done.
    task automatic run_sample(input string tag, input logic [cb-1:0] x);
        logic [19:0] seq;
        int          n;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.x_in  = x;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.x_in  = '0;
        n   = 1;
        seq = {16'd0, bus_if.sel_cte};
        while (!bus_if.done && n < 20) begin
            @(negedge clk);
            n++;
            if (n <= 5) seq = {seq[15:0], bus_if.sel_cte};
        end
        chk_val({tag, "_lat"}, 32'(n - 1), 32'd6);
        chk_val({tag, "_seq"}, {12'd0, seq}, 32'h0005_6712);
        chk_val({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
        y_got   = bus_if.y_out;
        sat_got = bus_if.sat;
        $display("sample %s x=0x%07h y=0x%07h sat=%0d lat=%0d",
                 tag, x, y_got, sat_got, n - 1);
    endtask

    int                  done_k [$];
    logic [cb-1:0]       done_y [$];
    logic [cb-1:0]       exp_y  [3];

    initial begin
        bus_if.start = 1'b0;
        bus_if.x_in  = '0;

        // Reset state.
        #1;
        chk_val("rst_y",    {7'd0, bus_if.y_out},   32'd0);
        chk_val("rst_done", {31'd0, bus_if.done},   32'd0);
        chk_val("rst_sat",  {31'd0, bus_if.sat},    32'd0);
        chk_val("rst_busy", {31'd0, bus_if.busy},   32'd0);
        chk_val("rst_sel",  {28'd0, bus_if.sel_cte}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // A sample to get a non-zero y_out before the mid-MAC reset.
        run_sample("pre", 25'h0004000);
        chk_val("pre_y", {7'd0, y_got}, 32'h0003FDF);

        // Reset asserted in the middle of MAC.
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.x_in  = 25'h0001234;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.x_in  = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_val("mid_y",    {7'd0, bus_if.y_out},    32'd0);
        chk_val("mid_done", {31'd0, bus_if.done},    32'd0);
        chk_val("mid_sat",  {31'd0, bus_if.sat},     32'd0);
        chk_val("mid_busy", {31'd0, bus_if.busy},    32'd0);
        chk_val("mid_sel",  {28'd0, bus_if.sel_cte}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        begin
            int nd = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (bus_if.done) nd++;
            end
            chk_val("mid_nodone", 32'(nd), 32'd0);
        end

        // Impulse response from clean history.
        run_sample("imp0", 25'h0004000);
        chk_val("imp0_y",   {7'd0, y_got},    32'h0003FDF);
        chk_val("imp0_sat", {31'd0, sat_got}, 32'd0);
        run_sample("imp1", 25'h0000000);
        chk_val("imp1_y",   {7'd0, y_got},    32'h1FFFFBE);
        chk_val("imp1_sat", {31'd0, sat_got}, 32'd0);
        run_sample("imp2", 25'h0000000);
        chk_val("imp2_y",   {7'd0, y_got},    32'h00000E7);
        chk_val("imp2_sat", {31'd0, sat_got}, 32'd0);

        // Saturation at the negative limit.
        pulse_reset();
        run_sample("sat0", 25'h0FFFFFF);
        chk_val("sat0_y",   {7'd0, y_got},    32'h0FF7BFF);
        chk_val("sat0_sat", {31'd0, sat_got}, 32'd0);
        run_sample("sat1", 25'h1000000);
        chk_val("sat1_y",   {7'd0, y_got},    32'h1000000);
        chk_val("sat1_sat", {31'd0, sat_got}, 32'd1);

        // Back-to-back: start held 21 cycles; only every 7th x_in is taken,
        // the rest carry a junk value that must never be captured.
        pulse_reset();
        exp_y[0] = 25'h0003FDF;
        exp_y[1] = 25'h1FFFFBE;
        exp_y[2] = 25'h00000E7;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus_if.done) begin
                done_k.push_back(k);
                done_y.push_back(bus_if.y_out);
                $display("b2b done at cycle %0d y=0x%07h", k, bus_if.y_out);
            end
            bus_if.start = (k < 21);
            if (k == 0)
                bus_if.x_in = 25'h0004000;
            else if (k < 21 && (k % 7) != 0)
                bus_if.x_in = 25'h0ABCDEF;
            else
                bus_if.x_in = '0;
        end
        bus_if.start = 1'b0;
        chk_val("b2b_count", 32'(done_k.size()), 32'd3);
        for (int i = 0; i < done_k.size() && i < 3; i++) begin
            chk_val($sformatf("b2b_cyc%0d", i), 32'(done_k[i]), 32'(7 * (i + 1)));
            chk_val($sformatf("b2b_y%0d", i), {7'd0, done_y[i]}, {7'd0, exp_y[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
